// File: rtl/snake_engine.sv
// snake_engine: segment position memory with tick-driven movement and growth, edge handling,
// a serial self-collision scan and a registered per-pixel head/body hit test.
module snake_engine #(
   parameter int unsigned MAX_LEN  = 32,
   parameter int unsigned INIT_LEN = 3,
   parameter int unsigned CELL     = 10,
   parameter int unsigned X_MAX    = 640,
   parameter int unsigned Y_MAX    = 480,
   parameter int unsigned START_X  = 300,
   parameter int unsigned START_Y  = 300,
   parameter int unsigned WRAP     = 0,
   parameter int unsigned LW       = $clog2(MAX_LEN + 1)
) (
   input  logic          clk_d,
   input  logic          reset,
   input  logic          start,
   input  logic          tick,
   input  logic [2:0]    direction,
   input  logic          grow,
   input  logic [9:0]    xCount,
   input  logic [9:0]    yCount,
   output logic          snakeHead,
   output logic          snakeBody,
   output logic [LW-1:0] length,
   output logic          collide,
   output logic          busy
);

   localparam int unsigned IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [10:0] CellW = 11'(CELL);
   localparam logic [10:0] XLast = 11'(X_MAX - CELL);
   localparam logic [10:0] YLast = 11'(Y_MAX - CELL);
   localparam bit          Wrap  = (WRAP != 0);

   localparam logic [2:0] DirUp    = 3'b001;
   localparam logic [2:0] DirLeft  = 3'b010;
   localparam logic [2:0] DirDown  = 3'b011;
   localparam logic [2:0] DirRight = 3'b100;
   localparam logic [2:0] DirHold  = 3'b111;

   typedef enum logic [1:0] {StIdle, StRun, StCheck, StDead} state_e;

   state_e        r_state, w_state_nxt;
   logic [9:0]    r_seg_x [MAX_LEN];
   logic [9:0]    r_seg_y [MAX_LEN];
   logic [LW-1:0] r_len;
   logic [2:0]    r_last_dir;
   logic [IW-1:0] r_idx;
   logic          r_head, r_body;

   logic [2:0]    w_dir;
   logic          w_reverse;
   logic [10:0]   w_hx, w_hy;
   logic          w_out;
   logic          w_match;
   logic          w_move;
   logic [LW-1:0] w_last_idx;
   logic          w_head_hit, w_body_hit;

   // Left/top edges inclusive, right/bottom exclusive; 11-bit so segX+CELL cannot overflow.
   function automatic logic cell_hit(input logic [9:0] px, input logic [9:0] py,
                                     input logic [9:0] sx, input logic [9:0] sy);
      logic [10:0] x11, y11, sx11, sy11;
      x11  = {1'b0, px};
      y11  = {1'b0, py};
      sx11 = {1'b0, sx};
      sy11 = {1'b0, sy};
      return (x11 >= sx11) && (x11 < sx11 + CellW) && (y11 >= sy11) && (y11 < sy11 + CellW);
   endfunction

   always_comb begin
      w_reverse = ((direction == DirUp)    && (r_last_dir == DirDown))  ||
                  ((direction == DirDown)  && (r_last_dir == DirUp))    ||
                  ((direction == DirLeft)  && (r_last_dir == DirRight)) ||
                  ((direction == DirRight) && (r_last_dir == DirLeft));
      w_dir = r_last_dir;
      case (direction)
         DirUp, DirLeft, DirDown, DirRight:
            w_dir = (w_reverse && (r_len > LW'(1))) ? r_last_dir : direction;
         DirHold: w_dir = DirHold;
         default: w_dir = r_last_dir;
      endcase
   end

   // Candidate head position; w_out flags a step across a playfield edge.
   always_comb begin
      w_hx  = {1'b0, r_seg_x[0]};
      w_hy  = {1'b0, r_seg_y[0]};
      w_out = 1'b0;
      case (w_dir)
         DirUp: begin
            if (w_hy < CellW) begin
               w_out = 1'b1;
               w_hy  = YLast;
            end else begin
               w_hy = w_hy - CellW;
            end
         end
         DirLeft: begin
            if (w_hx < CellW) begin
               w_out = 1'b1;
               w_hx  = XLast;
            end else begin
               w_hx = w_hx - CellW;
            end
         end
         DirDown: begin
            if (w_hy + CellW > YLast) begin
               w_out = 1'b1;
               w_hy  = 11'd0;
            end else begin
               w_hy = w_hy + CellW;
            end
         end
         DirRight: begin
            if (w_hx + CellW > XLast) begin
               w_out = 1'b1;
               w_hx  = 11'd0;
            end else begin
               w_hx = w_hx + CellW;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_move      = 1'b0;
      w_last_idx  = r_len - LW'(1);
      w_match     = (r_seg_x[r_idx] == r_seg_x[0]) && (r_seg_y[r_idx] == r_seg_y[0]);
      unique case (r_state)
         StIdle: if (start) w_state_nxt = StRun;
         StRun: begin
            if (tick && (w_dir != DirHold)) begin
               if (w_out && !Wrap) begin
                  w_state_nxt = StDead;
               end else begin
                  w_move      = 1'b1;
                  w_state_nxt = StCheck;
               end
            end
         end
         StCheck: begin
            if (r_len <= LW'(1))                  w_state_nxt = StRun;
            else if (w_match)                     w_state_nxt = StDead;
            else if (LW'(r_idx) == w_last_idx)    w_state_nxt = StRun;
         end
         StDead: ;
         default: w_state_nxt = StIdle;
      endcase
      // Dropping start aborts everything, including a scan in progress.
      if (!start) w_state_nxt = StIdle;
   end

   always_ff @(posedge clk_d or negedge reset) begin
      if (!reset) r_state <= StIdle;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_d or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < MAX_LEN; k++) begin
            r_seg_x[k] <= 10'(START_X);
            r_seg_y[k] <= 10'(START_Y);
         end
         r_len      <= LW'(INIT_LEN);
         r_last_dir <= DirHold;
         r_idx      <= IW'(1);
      end else if (!start) begin
         for (int k = 0; k < MAX_LEN; k++) begin
            r_seg_x[k] <= 10'(START_X);
            r_seg_y[k] <= 10'(START_Y);
         end
         r_len      <= LW'(INIT_LEN);
         r_last_dir <= DirHold;
         r_idx      <= IW'(1);
      end else if (w_move) begin
         for (int k = 1; k < MAX_LEN; k++) begin
            r_seg_x[k] <= r_seg_x[k-1];
            r_seg_y[k] <= r_seg_y[k-1];
         end
         r_seg_x[0] <= w_hx[9:0];
         r_seg_y[0] <= w_hy[9:0];
         r_last_dir <= w_dir;
         if (grow && (r_len < LW'(MAX_LEN))) r_len <= r_len + LW'(1);
         r_idx <= IW'(1);
      end else if (r_state == StCheck) begin
         r_idx <= r_idx + IW'(1);
      end
   end

   always_comb begin
      w_head_hit = cell_hit(xCount, yCount, r_seg_x[0], r_seg_y[0]);
      w_body_hit = 1'b0;
      for (int k = 1; k < MAX_LEN; k++) begin
         if ((LW'(k) < r_len) && cell_hit(xCount, yCount, r_seg_x[k], r_seg_y[k])) begin
            w_body_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_d or negedge reset) begin
      if (!reset) begin
         r_head <= 1'b0;
         r_body <= 1'b0;
      end else begin
         r_head <= w_head_hit;
         r_body <= w_body_hit;
      end
   end

   assign snakeHead = r_head;
   assign snakeBody = r_body;
   assign length    = r_len;
   assign collide   = (r_state == StDead);
   assign busy      = (r_state == StCheck);

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: a fatal-edge instance and a wrapping length-1 instance.
module tb_snake_engine;

   localparam int LW = 6;

   logic          clk_d = 1'b0;
   logic          reset;
   logic          start, tick, grow;
   logic [2:0]    direction;
   logic [9:0]    xCount, yCount;
   logic          snakeHead, snakeBody, collide, busy;
   logic [LW-1:0] length;

   logic          start_w, tick_w, grow_w;
   logic [2:0]    dir_w;
   logic [9:0]    xc_w, yc_w;
   logic          head_w, body_w, coll_w, busy_w;
   logic [LW-1:0] len_w;

   int checks = 0;
   int errors = 0;

   string      tag_q[$];
   logic [1:0] hb_q[$];

   always #5 clk_d = ~clk_d;

   snake_engine #(
      .MAX_LEN(32), .INIT_LEN(3), .CELL(10), .X_MAX(640), .Y_MAX(480),
      .START_X(300), .START_Y(300), .WRAP(0)
   ) dut (
      .clk_d(clk_d), .reset(reset), .start(start), .tick(tick), .direction(direction),
      .grow(grow), .xCount(xCount), .yCount(yCount), .snakeHead(snakeHead),
      .snakeBody(snakeBody), .length(length), .collide(collide), .busy(busy)
   );

   snake_engine #(
      .MAX_LEN(32), .INIT_LEN(1), .CELL(10), .X_MAX(640), .Y_MAX(480),
      .START_X(10), .START_Y(300), .WRAP(1)
   ) dut_w (
      .clk_d(clk_d), .reset(reset), .start(start_w), .tick(tick_w), .direction(dir_w),
      .grow(grow_w), .xCount(xc_w), .yCount(yc_w), .snakeHead(head_w),
      .snakeBody(body_w), .length(len_w), .collide(coll_w), .busy(busy_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, req);
      end
   endtask

   task automatic pulse_tick(input int sel);
      if (sel == 0) tick = 1'b1;
      else          tick_w = 1'b1;
      @(negedge clk_d);
      tick   = 1'b0;
      tick_w = 1'b0;
   endtask

   task automatic wait_idle(input int sel, input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (((sel == 0) ? busy : busy_w) == 1'b0) begin
            done = 1'b1;
            break;
         end
         @(negedge clk_d);
      end
      if (!done) begin
         checks++;
         errors++;
         $error("FAIL %s: busy observed 1 after 64 cycles, required 0", tag);
      end
   endtask

   task automatic move(input int sel, input logic [2:0] dir, input logic g);
      if (sel == 0) begin
         direction = dir;
         grow      = g;
      end else begin
         dir_w  = dir;
         grow_w = g;
      end
      pulse_tick(sel);
      wait_idle(sel, "scan_end");
   endtask

   // Pixel expectation is queued when the coordinate is driven, compared one clock later.
   task automatic probe(input int sel, input logic [9:0] x, input logic [9:0] y,
                        input logic h, input logic b, input string tag);
      logic [1:0] obs, req;
      string      t;
      if (sel == 0) begin
         xCount = x;
         yCount = y;
      end else begin
         xc_w = x;
         yc_w = y;
      end
      tag_q.push_back(tag);
      hb_q.push_back({h, b});
      @(negedge clk_d);
      obs = (sel == 0) ? {snakeHead, snakeBody} : {head_w, body_w};
      req = hb_q.pop_front();
      t   = tag_q.pop_front();
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: head,body observed %b required %b", t, obs, req);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; start = 1'b0; tick = 1'b0; grow = 1'b0; direction = 3'b111;
      xCount = 10'd300; yCount = 10'd300;
      start_w = 1'b0; tick_w = 1'b0; grow_w = 1'b0; dir_w = 3'b111;
      xc_w = 10'd10; yc_w = 10'd300;
      repeat (2) @(negedge clk_d);
      chk("rst_len", 32'(length), 32'd3);
      chk("rst_collide", 32'(collide), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_head", 32'(snakeHead), 32'd0);
      chk("rst_body", 32'(snakeBody), 32'd0);
      chk("rst_len_w", 32'(len_w), 32'd1);

      reset = 1'b1;
      start = 1'b1;
      @(negedge clk_d);
      direction = 3'b100;
      pulse_tick(0);
      chk("busy_c1", 32'(busy), 32'd1);
      @(negedge clk_d);
      chk("busy_c2", 32'(busy), 32'd1);
      @(negedge clk_d);
      chk("busy_end", 32'(busy), 32'd0);
      chk("len_after_move", 32'(length), 32'd3);
      probe(0, 10'd310, 10'd300, 1'b1, 1'b0, "head_corner");
      probe(0, 10'd320, 10'd300, 1'b0, 1'b0, "head_right_edge");
      probe(0, 10'd309, 10'd300, 1'b0, 1'b1, "body_edge");

      // Reversal with length 3 keeps the snake moving right.
      move(0, 3'b010, 1'b0);
      probe(0, 10'd320, 10'd300, 1'b1, 1'b0, "reversal_head");
      probe(0, 10'd310, 10'd300, 1'b0, 1'b1, "reversal_body");

      for (int i = 0; i < 29; i++) begin
         move(0, 3'b100, 1'b1);
         if (i == 27) chk("len_31", 32'(length), 32'd31);
      end
      chk("len_sat", 32'(length), 32'd32);
      chk("grow_no_collide", 32'(collide), 32'd0);
      probe(0, 10'd610, 10'd300, 1'b1, 1'b0, "grow_head");
      move(0, 3'b100, 1'b1);
      chk("len_stays_32", 32'(length), 32'd32);
      move(0, 3'b100, 1'b0);
      probe(0, 10'd630, 10'd300, 1'b1, 1'b0, "edge_head");

      pulse_tick(0);
      chk("edge_collide", 32'(collide), 32'd1);
      chk("edge_busy", 32'(busy), 32'd0);
      probe(0, 10'd630, 10'd300, 1'b1, 1'b0, "dead_head");
      probe(0, 10'd625, 10'd300, 1'b0, 1'b1, "dead_body");
      pulse_tick(0);
      @(negedge clk_d);
      chk("dead_collide_held", 32'(collide), 32'd1);
      chk("dead_len", 32'(length), 32'd32);
      probe(0, 10'd630, 10'd300, 1'b1, 1'b0, "dead_frozen");

      start = 1'b0;
      @(negedge clk_d);
      chk("restart_collide", 32'(collide), 32'd0);
      chk("restart_len", 32'(length), 32'd3);
      probe(0, 10'd300, 10'd300, 1'b1, 1'b1, "restart_head");
      probe(0, 10'd630, 10'd300, 1'b0, 1'b0, "restart_old_head");

      start = 1'b1;
      @(negedge clk_d);
      move(0, 3'b100, 1'b1);
      move(0, 3'b100, 1'b1);
      chk("len_5", 32'(length), 32'd5);
      direction = 3'b011;
      grow      = 1'b0;
      pulse_tick(0);
      chk("down_busy", 32'(busy), 32'd1);
      pulse_tick(0);
      wait_idle(0, "down_scan");
      probe(0, 10'd320, 10'd310, 1'b1, 1'b0, "tick_dropped_head");
      chk("down_collide", 32'(collide), 32'd0);
      move(0, 3'b010, 1'b0);
      chk("left_collide", 32'(collide), 32'd0);
      move(0, 3'b001, 1'b0);
      chk("self_collide", 32'(collide), 32'd1);
      probe(0, 10'd310, 10'd300, 1'b1, 1'b1, "self_head");

      start_w = 1'b1;
      @(negedge clk_d);
      dir_w = 3'b100;
      pulse_tick(1);
      chk("w_busy_1", 32'(busy_w), 32'd1);
      @(negedge clk_d);
      chk("w_busy_end", 32'(busy_w), 32'd0);
      chk("w_len", 32'(len_w), 32'd1);
      probe(1, 10'd20, 10'd300, 1'b1, 1'b0, "w_right");
      move(1, 3'b010, 1'b0);
      probe(1, 10'd10, 10'd300, 1'b1, 1'b0, "w_len1_reverse");
      probe(1, 10'd20, 10'd300, 1'b0, 1'b0, "w_no_body");
      move(1, 3'b010, 1'b0);
      probe(1, 10'd0, 10'd300, 1'b1, 1'b0, "w_at_zero");
      move(1, 3'b010, 1'b0);
      probe(1, 10'd630, 10'd300, 1'b1, 1'b0, "w_wrapped");
      probe(1, 10'd0, 10'd300, 1'b0, 1'b0, "w_left_edge_clear");
      chk("w_collide", 32'(coll_w), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
